// File: rtl/pbgen_tx.sv
`default_nettype none
// ============================================================================
// Module   : pbgen_tx
// Purpose  : Parity-bit generator and serial transmitter. Frame is start(0),
//            ina..ind, parity, stop(1), each held CLKS_PER_BIT clocks.
//            Optional macro PBGEN_ERR_INJECT_EN adds inj_err to corrupt the
//            transmitted parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module pbgen_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          ODD_PARITY   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ina,
    input  logic inb,
    input  logic inc,
    input  logic ind,
`ifdef PBGEN_ERR_INJECT_EN
    input  logic inj_err,
`endif
    input  logic in_valid,
    output logic in_ready,
    output logic outs,
    output logic outp,
    output logic busy,
    output logic done
);

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_START  = 3'd1;
    localparam logic [2:0] C_ST_DATA   = 3'd2;
    localparam logic [2:0] C_ST_PARITY = 3'd3;
    localparam logic [2:0] C_ST_STOP   = 3'd4;

    localparam logic [7:0] C_CNT_LAST  = 8'(CLKS_PER_BIT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] bit_idx_q, bit_idx_d;
    logic [3:0] shreg_q, shreg_d;
    logic       outp_q, outp_d;
    logic       outs_q, outs_d;

    logic       w_accept;
    logic       w_cnt_wrap;
    logic       w_inj;

    assign w_accept   = (state_q == C_ST_IDLE) && in_valid;
    assign w_cnt_wrap = (cnt_q == C_CNT_LAST);

`ifdef PBGEN_ERR_INJECT_EN
    logic inj_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inj_q <= 1'b0;
        end else if (w_accept) begin
            inj_q <= inj_err;
        end
    end

    assign w_inj = inj_q;
`else
    assign w_inj = 1'b0;
`endif

    // Next-state: the counter runs in every non-idle state and advances the
    // state (or data bit index) when it wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        outp_d    = outp_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    state_d   = C_ST_START;
                    cnt_d     = 8'd0;
                    bit_idx_d = 2'd0;
                    shreg_d   = {ind, inc, inb, ina};
                    outp_d    = ina ^ inb ^ inc ^ ind ^ ODD_PARITY;
                end
            end
            default: begin
                if (w_cnt_wrap) begin
                    cnt_d = 8'd0;
                    case (state_q)
                        C_ST_START:  state_d = C_ST_DATA;
                        C_ST_DATA: begin
                            bit_idx_d = bit_idx_q + 2'd1;
                            shreg_d   = {1'b0, shreg_q[3:1]};
                            if (bit_idx_q == 2'd3) begin
                                state_d = C_ST_PARITY;
                            end
                        end
                        C_ST_PARITY: state_d = C_ST_STOP;
                        default:     state_d = C_ST_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // Line level is decided from the upcoming state so outs is a clean flop.
    always_comb begin
        outs_d = 1'b1;
        case (state_d)
            C_ST_START:  outs_d = 1'b0;
            C_ST_DATA:   outs_d = shreg_d[0];
            C_ST_PARITY: outs_d = outp_d ^ w_inj;
            default:     outs_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= C_ST_IDLE;
            cnt_q     <= 8'd0;
            bit_idx_q <= 2'd0;
            shreg_q   <= 4'd0;
            outp_q    <= 1'b0;
            outs_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            outp_q    <= outp_d;
            outs_q    <= outs_d;
        end
    end

    assign in_ready = (state_q == C_ST_IDLE);
    assign busy     = (state_q != C_ST_IDLE);
    assign done     = (state_q == C_ST_STOP) && w_cnt_wrap;
    assign outs     = outs_q;
    assign outp     = outp_q;

endmodule
`default_nettype wire

// File: tb/tb_pbgen_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pbgen_tx
// Purpose  : Directed self-checking bench for pbgen_tx (even parity with
//            4 clocks/bit, odd parity with 1 clock/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pbgen_tx;

    logic       clk;
    logic       rst_n;

    logic [3:0] e_word;
    logic       e_valid, e_inj;
    logic       e_ready, e_outs, e_outp, e_busy, e_done;

    logic [3:0] o_word;
    logic       o_valid;
    logic       o_ready, o_outs, o_outp, o_busy, o_done;

    int checks;
    int errors;

    pbgen_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) u_dut_even (
        .clk      (clk),
        .rst_n    (rst_n),
        .ina      (e_word[0]),
        .inb      (e_word[1]),
        .inc      (e_word[2]),
        .ind      (e_word[3]),
`ifdef PBGEN_ERR_INJECT_EN
        .inj_err  (e_inj),
`endif
        .in_valid (e_valid),
        .in_ready (e_ready),
        .outs     (e_outs),
        .outp     (e_outp),
        .busy     (e_busy),
        .done     (e_done)
    );

    pbgen_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b1)) u_dut_odd (
        .clk      (clk),
        .rst_n    (rst_n),
        .ina      (o_word[0]),
        .inb      (o_word[1]),
        .inc      (o_word[2]),
        .ind      (o_word[3]),
`ifdef PBGEN_ERR_INJECT_EN
        .inj_err  (1'b0),
`endif
        .in_valid (o_valid),
        .in_ready (o_ready),
        .outs     (o_outs),
        .outp     (o_outp),
        .busy     (o_busy),
        .done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line waveform: frame bit k held for cpb cycles.
    function automatic logic [63:0] expand(input logic [6:0] bits, input int cpb);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 7 * cpb; k++) r[k] = bits[k / cpb];
        return r;
    endfunction

    task automatic capture_e(input int n, output logic [63:0] s,
                             output logic [63:0] d, output logic [63:0] b);
        s = '0; d = '0; b = '0;
        for (int i = 0; i < n; i++) begin
            if (i != 0) tick;
            s[i] = e_outs; d[i] = e_done; b[i] = e_busy;
        end
    endtask

    task automatic capture_o(input int n, output logic [63:0] s,
                             output logic [63:0] d, output logic [63:0] b);
        s = '0; d = '0; b = '0;
        for (int i = 0; i < n; i++) begin
            if (i != 0) tick;
            s[i] = o_outs; d[i] = o_done; b[i] = o_busy;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if ({e_outs, e_ready, e_busy, e_done, e_outp} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_even cyc %0d: got %b expected 11000", i,
                         {e_outs, e_ready, e_busy, e_done, e_outp});
            end
            checks++;
            if ({o_outs, o_ready, o_busy, o_done, o_outp} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_odd cyc %0d: got %b expected 11000", i,
                         {o_outs, o_ready, o_busy, o_done, o_outp});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++;
            if ({e_outs, e_ready, e_busy, e_done} !== 4'b1100) begin
                errors++;
                $display("FAIL idle_even cyc %0d: got %b expected 1100", i,
                         {e_outs, e_ready, e_busy, e_done});
            end
            checks++;
            if ({o_outs, o_ready, o_busy, o_done} !== 4'b1100) begin
                errors++;
                $display("FAIL idle_odd cyc %0d: got %b expected 1100", i,
                         {o_outs, o_ready, o_busy, o_done});
            end
        end
    endtask

    task automatic test_even_parity;
        logic [63:0] s, d, b, es;
        e_word = 4'b1011; e_valid = 1'b1;
        tick;
        e_valid = 1'b0; e_word = 4'b0000;
        checks++;
        if (e_outp !== 1'b1) begin
            errors++;
            $display("FAIL even_outp: got %b expected 1", e_outp);
        end
        capture_e(28, s, d, b);
        es = expand(7'b1110110, 4);
        checks++;
        if (s !== es) begin
            errors++;
            $display("FAIL even_outs: got %h expected %h", s, es);
        end
        checks++;
        if (d !== (64'd1 << 27)) begin
            errors++;
            $display("FAIL even_done: got %h expected %h", d, 64'd1 << 27);
        end
        checks++;
        if (b !== ((64'd1 << 28) - 64'd1)) begin
            errors++;
            $display("FAIL even_busy: got %h expected %h", b, (64'd1 << 28) - 64'd1);
        end
        tick;
        checks++;
        if ({e_outs, e_ready, e_busy, e_done} !== 4'b1100) begin
            errors++;
            $display("FAIL even_after: got %b expected 1100",
                     {e_outs, e_ready, e_busy, e_done});
        end
    endtask

    task automatic test_odd_parity;
        logic [63:0] s, d, b, es;
        o_word = 4'b0000; o_valid = 1'b1;
        tick;
        o_valid = 1'b0;
        checks++;
        if (o_outp !== 1'b1) begin
            errors++;
            $display("FAIL odd_outp: got %b expected 1", o_outp);
        end
        capture_o(7, s, d, b);
        es = expand(7'b1100000, 1);
        checks++;
        if (s !== es) begin
            errors++;
            $display("FAIL odd_outs: got %h expected %h", s, es);
        end
        checks++;
        if (d !== (64'd1 << 6)) begin
            errors++;
            $display("FAIL odd_done: got %h expected %h", d, 64'd1 << 6);
        end
        checks++;
        if (b !== 64'h7f) begin
            errors++;
            $display("FAIL odd_busy: got %h expected 7f", b);
        end
        tick;
        checks++;
        if ({o_outs, o_ready, o_busy, o_done} !== 4'b1100) begin
            errors++;
            $display("FAIL odd_after: got %b expected 1100",
                     {o_outs, o_ready, o_busy, o_done});
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] s, d, b, es;
        e_word = 4'b1111; e_valid = 1'b1;
        tick;
        s = '0; d = '0;
        for (int i = 0; i < 28; i++) begin
            if (i != 0) tick;
            s[i] = e_outs; d[i] = e_done;
            if (i == 5)  e_word = 4'b0101;
            if (i == 20) e_word = 4'b0001;
        end
        es = expand(7'b1011110, 4);
        checks++;
        if (s !== es) begin
            errors++;
            $display("FAIL b2b_frame1_outs: got %h expected %h", s, es);
        end
        checks++;
        if ({e_outp, d} !== {1'b0, 64'd1 << 27}) begin
            errors++;
            $display("FAIL b2b_frame1_outp_done: got %b/%h expected 0/%h",
                     e_outp, d, 64'd1 << 27);
        end
        tick;
        checks++;
        if ({e_outs, e_ready, e_busy, e_done} !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_gap: got %b expected 1100",
                     {e_outs, e_ready, e_busy, e_done});
        end
        tick;
        e_valid = 1'b0;
        checks++;
        if ({e_busy, e_ready, e_outp, e_outs} !== 4'b1010) begin
            errors++;
            $display("FAIL b2b_second_accept: got %b expected 1010",
                     {e_busy, e_ready, e_outp, e_outs});
        end
        capture_e(28, s, d, b);
        es = expand(7'b1100010, 4);
        checks++;
        if (s !== es) begin
            errors++;
            $display("FAIL b2b_frame2_outs: got %h expected %h", s, es);
        end
        checks++;
        if (d !== (64'd1 << 27)) begin
            errors++;
            $display("FAIL b2b_frame2_done: got %h expected %h", d, 64'd1 << 27);
        end
        tick;
    endtask

    task automatic test_reset_midframe;
        logic [63:0] s, d, b, es;
        e_word = 4'b1010; e_valid = 1'b1;
        tick;
        e_valid = 1'b0;
        for (int i = 1; i <= 6; i++) tick;
        checks++;
        if ({e_busy, e_outs} !== 2'b10) begin
            errors++;
            $display("FAIL midframe_data: got %b expected 10", {e_busy, e_outs});
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if ({e_outs, e_busy, e_ready, e_done, e_outp} !== 5'b10100) begin
            errors++;
            $display("FAIL midframe_reset: got %b expected 10100",
                     {e_outs, e_busy, e_ready, e_done, e_outp});
        end
        rst_n = 1'b1;
        tick;
        e_word = 4'b0110; e_valid = 1'b1;
        tick;
        e_valid = 1'b0;
        checks++;
        if (e_outp !== 1'b0) begin
            errors++;
            $display("FAIL midframe_new_outp: got %b expected 0", e_outp);
        end
        capture_e(28, s, d, b);
        es = expand(7'b1001100, 4);
        checks++;
        if (s !== es) begin
            errors++;
            $display("FAIL midframe_new_outs: got %h expected %h", s, es);
        end
        checks++;
        if (d !== (64'd1 << 27)) begin
            errors++;
            $display("FAIL midframe_new_done: got %h expected %h", d, 64'd1 << 27);
        end
        tick;
    endtask

`ifdef PBGEN_ERR_INJECT_EN
    task automatic test_err_inject;
        logic [63:0] s, d, b, es;
        e_word = 4'b0011; e_inj = 1'b1; e_valid = 1'b1;
        tick;
        e_valid = 1'b0; e_inj = 1'b0;
        checks++;
        if (e_outp !== 1'b0) begin
            errors++;
            $display("FAIL inj_outp: got %b expected 0", e_outp);
        end
        capture_e(28, s, d, b);
        es = expand(7'b1100110, 4);
        checks++;
        if (s !== es) begin
            errors++;
            $display("FAIL inj_outs: got %h expected %h", s, es);
        end
        checks++;
        if ((s[5] ^ s[9] ^ s[13] ^ s[17] ^ s[21]) !== 1'b1) begin
            errors++;
            $display("FAIL inj_rx_check: got %b expected 1",
                     s[5] ^ s[9] ^ s[13] ^ s[17] ^ s[21]);
        end
        tick;
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        e_word  = 4'b0000; e_valid = 1'b0; e_inj = 1'b0;
        o_word  = 4'b0000; o_valid = 1'b0;
        #1;
        test_reset;
        test_even_parity;
        test_odd_parity;
        test_back_to_back;
        test_reset_midframe;
`ifdef PBGEN_ERR_INJECT_EN
        test_err_inject;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
